// File: rtl/jt51_acc_mix_pkg.sv
// Shared widths, saturation limits and the accumulator clamp helper for the jt51 output mixer.
// Pure declarations: no state, no latency, no flow control.
package jt51_acc_mix_pkg;
  localparam int OP_W     = 14;
  localparam int ACC_W    = 16;
  localparam int MAN_W    = 10;
  localparam int EXP_W    = 3;
  localparam int NOISE_W  = 11;
  localparam int CH_NUM   = 8;

  localparam logic [ACC_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [ACC_W-1:0] SAT_NEG = 16'h8000;

  // Clamp a 17-bit two's complement sum back into 16 bits.
  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] v);
    if (v[ACC_W] != v[ACC_W-1]) return v[ACC_W] ? SAT_NEG : SAT_POS;
    return v[ACC_W-1:0];
  endfunction
endpackage

// File: rtl/jt51_acc_mix_if.sv
// Slot-rate bus between the operator pipeline and the mixer: phase strobes, operator data, mixed samples.
// One slot per clock, no handshake; the consumer samples every cycle.
interface jt51_acc_mix_if;
  import jt51_acc_mix_pkg::*;

  logic                      m1_enters;
  logic                      m2_enters;
  logic                      c1_enters;
  logic                      c2_enters;
  logic                      op31_acc;
  logic [1:0]                rl_I;
  logic [2:0]                con_I;
  logic signed [OP_W-1:0]    op_out;
  logic                      ne;
  logic signed [NOISE_W-1:0] noise;
  logic signed [ACC_W-1:0]   xleft;
  logic signed [ACC_W-1:0]   xright;
  logic signed [ACC_W-1:0]   left;
  logic signed [ACC_W-1:0]   right;

  modport master (
    output m1_enters, m2_enters, c1_enters, c2_enters, op31_acc,
    output rl_I, con_I, op_out, ne, noise,
    input  xleft, xright, left, right
  );

  modport slave (
    input  m1_enters, m2_enters, c1_enters, c2_enters, op31_acc,
    input  rl_I, con_I, op_out, ne, noise,
    output xleft, xright, left, right
  );
endinterface

// File: rtl/jt51_exp2lin.sv
// DAC-style expander: signed mantissa shifted left by exp-1; exponent 0 is silence.
// Combinational, no flow control.
module jt51_exp2lin
  import jt51_acc_mix_pkg::*;
(
  input  logic signed [MAN_W-1:0] i_man,
  input  logic        [EXP_W-1:0] i_exp,
  output logic signed [ACC_W-1:0] o_lin
);
  logic signed [ACC_W-1:0] w_ext;

  assign w_ext = {{(ACC_W-MAN_W){i_man[MAN_W-1]}}, i_man};
  assign o_lin = (i_exp == '0) ? '0 : (w_ext <<< (i_exp - 3'd1));
endmodule

// File: rtl/jt51_lin2exp.sv
// DAC-style compressor: 16-bit linear sample to 10-bit mantissa plus 3-bit exponent.
// Combinational, no flow control.
module jt51_lin2exp
  import jt51_acc_mix_pkg::*;
(
  input  logic signed [ACC_W-1:0] i_lin,
  output logic        [MAN_W-1:0] o_man,
  output logic        [EXP_W-1:0] o_exp
);
  logic [5:0] w_mag;

  // A 1 here marks the first bit below the sign that differs from it.
  assign w_mag = i_lin[14:9] ^ {6{i_lin[15]}};

  always_comb begin
    casez (w_mag)
      6'b1?????: begin o_exp = 3'd7; o_man = i_lin[15:6]; end
      6'b01????: begin o_exp = 3'd6; o_man = i_lin[14:5]; end
      6'b001???: begin o_exp = 3'd5; o_man = i_lin[13:4]; end
      6'b0001??: begin o_exp = 3'd4; o_man = i_lin[12:3]; end
      6'b00001?: begin o_exp = 3'd3; o_man = i_lin[11:2]; end
      6'b000001: begin o_exp = 3'd2; o_man = i_lin[10:1]; end
      default:   begin o_exp = 3'd1; o_man = i_lin[9:0];  end
    endcase
  end
endmodule

// File: rtl/jt51_sh.sv
// Fixed-length shift register holding one word per channel; word re-emerges STAGES clocks later.
// Shifts every clock, no stall.
module jt51_sh #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_drop
);
  logic [WIDTH-1:0] r_bits [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_bits[i] <= '0;
    end else begin
      r_bits[0] <= i_din;
      for (int i = 1; i < STAGES; i++) r_bits[i] <= r_bits[i-1];
    end
  end

  assign o_drop = r_bits[STAGES-1];
endmodule

// File: rtl/jt51_acc_mix.sv
// Per-slot channel accumulator and stereo mixer; xleft/xright register once per sample on C1.
// Latency: channel sum visible 8 slots after push; left/right are combinational DAC views; no backpressure.
module jt51_acc_mix
  import jt51_acc_mix_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  jt51_acc_mix_if.slave bus
);
  logic signed [OP_W-1:0]  w_op_val;
  logic                    w_sum_en;
  logic signed [ACC_W-1:0] w_op_ext;
  logic signed [ACC_W-1:0] w_total;
  logic signed [ACC_W-1:0] w_opsum;
  logic        [ACC_W:0]   w_sum17;
  logic signed [ACC_W-1:0] w_len_term;
  logic signed [ACC_W-1:0] w_ren_term;

  logic                    r_sum_all;
  logic signed [ACC_W-1:0] r_pre_left;
  logic signed [ACC_W-1:0] r_pre_right;
  logic signed [ACC_W-1:0] r_xleft;
  logic signed [ACC_W-1:0] r_xright;

  logic [MAN_W-1:0] w_man_l, w_man_r;
  logic [EXP_W-1:0] w_exp_l, w_exp_r;

  // Operator 31 carries the noise generator when noise is enabled.
  assign w_op_val = (bus.ne && bus.op31_acc) ?
                    {{2{bus.noise[NOISE_W-1]}}, bus.noise, 1'b0} : bus.op_out;

  always_comb begin
    w_sum_en = 1'b1;
    case (bus.con_I)
      3'd0, 3'd1, 3'd2, 3'd3: w_sum_en = bus.m2_enters;
      3'd4:                   w_sum_en = bus.m1_enters | bus.m2_enters;
      3'd5, 3'd6:             w_sum_en = ~bus.c1_enters;
      default:                w_sum_en = 1'b1;
    endcase
  end

  assign w_op_ext = {{(ACC_W-OP_W){w_op_val[OP_W-1]}}, w_op_val};
  assign w_sum17  = {w_total[ACC_W-1], w_total} + {w_op_ext[ACC_W-1], w_op_ext};

  // C2 opens a fresh channel sum; later phases add into it.
  always_comb begin
    w_opsum = w_total;
    if (bus.c2_enters)  w_opsum = w_sum_en ? w_op_ext : '0;
    else if (w_sum_en)  w_opsum = sat_acc(w_sum17);
  end

  jt51_sh #(.WIDTH(ACC_W), .STAGES(CH_NUM)) u_sh (
    .clk    (clk),
    .rst    (rst),
    .i_din  (w_opsum),
    .o_drop (w_total)
  );

  assign w_len_term = bus.rl_I[0] ? w_total : '0;
  assign w_ren_term = bus.rl_I[1] ? w_total : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum_all   <= 1'b0;
      r_pre_left  <= '0;
      r_pre_right <= '0;
      r_xleft     <= '0;
      r_xright    <= '0;
    end else begin
      if (bus.c2_enters) begin
        r_pre_left  <= r_sum_all ? (r_pre_left  + w_len_term) : w_len_term;
        r_pre_right <= r_sum_all ? (r_pre_right + w_ren_term) : w_ren_term;
        r_sum_all   <= 1'b1;
      end
      // C1 closes the sample; it wins over C2 for sum_all when both fire.
      if (bus.c1_enters) begin
        r_xleft   <= r_pre_left;
        r_xright  <= r_pre_right;
        r_sum_all <= 1'b0;
      end
    end
  end

  assign bus.xleft  = r_xleft;
  assign bus.xright = r_xright;

  jt51_lin2exp u_l2e_l (.i_lin(r_xleft),  .o_man(w_man_l), .o_exp(w_exp_l));
  jt51_exp2lin u_e2l_l (.i_man(w_man_l), .i_exp(w_exp_l), .o_lin(bus.left));
  jt51_lin2exp u_l2e_r (.i_lin(r_xright), .o_man(w_man_r), .o_exp(w_exp_r));
  jt51_exp2lin u_e2l_r (.i_man(w_man_r), .i_exp(w_exp_r), .o_lin(bus.right));
endmodule

// File: tb/tb_jt51_acc_mix.sv
// Bench for jt51_acc_mix: quantizer/op_val tables, hand sequences for sample timing, then random slots vs a slot model.
module tb_jt51_acc_mix;
  import jt51_acc_mix_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  jt51_acc_mix_if bus();

  jt51_acc_mix dut (.clk(clk), .rst(rst), .bus(bus));

  logic signed [15:0] q_lin;
  logic signed [15:0] q_out;
  logic [9:0]         q_man;
  logic [2:0]         q_exp;
  jt51_lin2exp u_q_l2e (.i_lin(q_lin), .o_man(q_man), .o_exp(q_exp));
  jt51_exp2lin u_q_e2l (.i_man(q_man), .i_exp(q_exp), .o_lin(q_out));

  always #5 clk = ~clk;

  typedef struct {
    bit rst, m1, m2, c1, c2, op31, ne;
    bit [1:0] rl;
    bit [2:0] con;
    logic signed [13:0] op;
    logic signed [10:0] noise;
  } stim_t;

  typedef struct { logic [15:0] lin; logic [9:0] man; logic [2:0] ex; logic [15:0] out; } qvec_t;
  typedef struct { bit ne; bit op31; logic [10:0] noise; logic [13:0] op; logic [13:0] val; } ovec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: channel sums as a queue (front = newest), sample sums as plain ints.
  int m_q[$];
  int m_pl, m_pr, m_xl, m_xr;
  bit m_sa;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: dut=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sext16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Smallest exponent whose truncated mantissa fits in 10 signed bits.
  function automatic int quant(input int v);
    for (int e = 1; e <= 7; e++) begin
      int m;
      m = v >>> (e - 1);
      if (m >= -512 && m <= 511) return m * (1 << (e - 1));
    end
    return 0;
  endfunction

  function automatic int m_opval(input stim_t s);
    return (s.ne && s.op31) ? 2 * int'(s.noise) : int'(s.op);
  endfunction

  function automatic bit m_sumen(input stim_t s);
    case (s.con)
      3'd0, 3'd1, 3'd2, 3'd3: return s.m2;
      3'd4:                   return s.m1 | s.m2;
      3'd5, 3'd6:             return !s.c1;
      default:                return 1'b1;
    endcase
  endfunction

  function automatic int m_opsum(input stim_t s);
    int total;
    total = m_q[7];
    if (s.c2) return m_sumen(s) ? m_opval(s) : 0;
    if (m_sumen(s)) return clamp16(total + m_opval(s));
    return total;
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 8; i++) m_q.push_back(0);
    m_pl = 0; m_pr = 0; m_xl = 0; m_xr = 0; m_sa = 1'b0;
  endtask

  task automatic model_step(input stim_t s);
    int total, lt, rt, opsum, old_pl, old_pr;
    if (s.rst) begin
      model_reset();
    end else begin
      total  = m_q[7];
      opsum  = m_opsum(s);
      lt     = s.rl[0] ? total : 0;
      rt     = s.rl[1] ? total : 0;
      old_pl = m_pl;
      old_pr = m_pr;
      if (s.c2) begin
        m_pl = m_sa ? sext16(m_pl + lt) : lt;
        m_pr = m_sa ? sext16(m_pr + rt) : rt;
        m_sa = 1'b1;
      end
      if (s.c1) begin
        m_xl = old_pl;
        m_xr = old_pr;
        m_sa = 1'b0;
      end
      m_q.push_front(opsum);
      void'(m_q.pop_back());
    end
  endtask

  function automatic stim_t mk(input bit r, input bit c2, input bit m1, input bit m2, input bit c1,
                               input bit [2:0] con, input bit [1:0] rl, input logic signed [13:0] op);
    stim_t s;
    s.rst = r; s.c2 = c2; s.m1 = m1; s.m2 = m2; s.c1 = c1;
    s.con = con; s.rl = rl; s.op = op;
    s.ne = 1'b0; s.op31 = 1'b0; s.noise = '0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst           = s.rst;
    bus.m1_enters = s.m1;
    bus.m2_enters = s.m2;
    bus.c1_enters = s.c1;
    bus.c2_enters = s.c2;
    bus.op31_acc  = s.op31;
    bus.ne        = s.ne;
    bus.rl_I      = s.rl;
    bus.con_I     = s.con;
    bus.op_out    = s.op;
    bus.noise     = s.noise;
  endtask

  task automatic clock_slot(input stim_t s);
    @(posedge clk);
    model_step(s);
    @(negedge clk);
    check("xleft",  bus.xleft,  16'(m_xl));
    check("xright", bus.xright, 16'(m_xr));
    check("left",   bus.left,   16'(quant(m_xl)));
    check("right",  bus.right,  16'(quant(m_xr)));
  endtask

  task automatic do_slot(input stim_t s);
    logic [13:0] e14;
    drive(s);
    #1;
    e14 = 14'(m_opval(s));
    check("op_val", {2'b00, dut.w_op_val}, {2'b00, e14});
    check("opsum",  dut.w_opsum, 16'(m_opsum(s)));
    clock_slot(s);
  endtask

  // One sample period: C2, M1, M2, C1 phases of 8 channel slots each.
  task automatic run_round(input bit [2:0] con, input bit [1:0] rl, input logic signed [13:0] op);
    for (int p = 0; p < 4; p++)
      for (int ch = 0; ch < 8; ch++)
        do_slot(mk(1'b0, p == 0, p == 1, p == 2, p == 3, con, rl, op));
  endtask

  task automatic build_channel(input logic signed [13:0] op);
    for (int i = 0; i < 8; i++)  do_slot(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 2'b00, op));
    for (int i = 0; i < 24; i++) do_slot(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 2'b00, op));
  endtask

  initial begin
    qvec_t qtab[7];
    ovec_t otab[5];
    stim_t s;
    logic [31:0] r;

    qtab[0] = '{16'h0123, 10'h123, 3'd1, 16'h0123};
    qtab[1] = '{16'h7FFF, 10'h1FF, 3'd7, 16'h7FC0};
    qtab[2] = '{16'h8000, 10'h200, 3'd7, 16'h8000};
    qtab[3] = '{16'hFFFF, 10'h3FF, 3'd1, 16'hFFFF};
    qtab[4] = '{16'h0400, 10'h100, 3'd3, 16'h0400};
    qtab[5] = '{16'h1234, 10'h123, 3'd5, 16'h1230};
    qtab[6] = '{16'hC000, 10'h200, 3'd6, 16'hC000};

    otab[0] = '{1'b1, 1'b1, 11'h400, 14'd123,  14'h3800};
    otab[1] = '{1'b1, 1'b0, 11'h400, 14'd123,  14'd123};
    otab[2] = '{1'b0, 1'b1, 11'h400, 14'h3FFB, 14'h3FFB};
    otab[3] = '{1'b1, 1'b1, 11'h3FF, 14'd0,    14'h07FE};
    otab[4] = '{1'b1, 1'b1, 11'h7FF, 14'd7,    14'h3FFE};

    model_reset();
    q_lin = '0;
    drive(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 14'd0));

    do_slot(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 14'd0));
    do_slot(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 14'd0));
    check("rst_xleft",  bus.xleft,  16'h0);
    check("rst_xright", bus.xright, 16'h0);
    check("rst_left",   bus.left,   16'h0);
    check("rst_right",  bus.right,  16'h0);

    for (int i = 0; i < 7; i++) begin
      q_lin = qtab[i].lin;
      #1;
      check("q_man", {6'd0, q_man}, {6'd0, qtab[i].man});
      check("q_exp", {13'd0, q_exp}, {13'd0, qtab[i].ex});
      check("q_out", q_out, qtab[i].out);
    end

    for (int i = 0; i < 5; i++) begin
      s = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, otab[i].op);
      s.ne = otab[i].ne; s.op31 = otab[i].op31; s.noise = otab[i].noise;
      drive(s);
      #1;
      check("op_val_tab", {2'b00, dut.w_op_val}, {2'b00, otab[i].val});
    end

    // Eight channels, all four operators at 100, left only.
    do_slot(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 2'b01, 14'd0));
    run_round(3'd7, 2'b01, 14'd100);
    run_round(3'd7, 2'b01, 14'd100);
    check("mix_xleft",  bus.xleft,  16'd3200);
    check("mix_xright", bus.xright, 16'd0);
    check("mix_left",   bus.left,   16'h0C80);

    // C1 and C2 together: every slot reloads pre_left instead of accumulating.
    for (int i = 0; i < 8; i++) do_slot(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 2'b01, 14'd100));
    do_slot(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 2'b01, 14'd100));
    check("c1c2_overlap", bus.xleft, 16'd400);

    do_slot(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 2'b00, 14'd0));
    build_channel(14'h1FC0);
    s = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 2'b00, 14'h1000);
    drive(s);
    #1;
    check("sat_pos", dut.w_opsum, 16'h7FFF);
    clock_slot(s);

    do_slot(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 2'b00, 14'd0));
    build_channel(14'h2000);
    s = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 2'b00, 14'h3FFF);
    drive(s);
    #1;
    check("sat_neg", dut.w_opsum, 16'h8000);
    clock_slot(s);

    // Reset in the middle of a sample, then two clean samples.
    do_slot(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 2'b11, 14'd0));
    run_round(3'd7, 2'b11, 14'd100);
    for (int i = 0; i < 8; i++) do_slot(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 2'b11, 14'd100));
    do_slot(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 2'b11, 14'd100));
    check("midrst_xleft",  bus.xleft,  16'h0);
    check("midrst_xright", bus.xright, 16'h0);
    run_round(3'd7, 2'b11, 14'd100);
    check("nostale_xleft", bus.xleft, 16'h0);
    run_round(3'd7, 2'b11, 14'd100);
    check("post_xleft",  bus.xleft,  16'd3200);
    check("post_xright", bus.xright, 16'd3200);

    for (int n = 0; n < 1500; n++) begin
      r = $urandom;
      s.rst  = ($urandom_range(0, 149) == 0);
      s.c2   = ($urandom_range(0, 2) == 0);
      s.m1   = ($urandom_range(0, 2) == 0);
      s.m2   = ($urandom_range(0, 2) == 0);
      s.c1   = ($urandom_range(0, 3) == 0);
      s.op31 = r[31];
      s.ne   = r[30];
      s.rl   = r[29:28];
      s.con  = r[27:25];
      s.op   = r[13:0];
      s.noise = r[24:14];
      do_slot(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/jt51_acc_mix.md
JT51_ACC_MIX -- requirements
Module: jt51_acc_mix

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have ports m1_enters, m2_enters, c1_enters, c2_enters, inputs, 1 bit each: operator-phase strobes for the current slot.
REQ-004 SHALL have port op31_acc, input, 1 bit: current slot is operator 31.
REQ-005 SHALL have port rl_I, input, 2 bits: bit1 = right enable, bit0 = left enable.
REQ-006 SHALL have port con_I, input, 3 bits: channel connection algorithm 0..7.
REQ-007 SHALL have port op_out, input, signed 14 bits: operator output.
REQ-008 SHALL have ports ne, input, 1 bit (noise enable), and noise, input, signed 11 bits.
REQ-009 SHALL have ports xleft and xright, output, signed 16 bits, registered: exact sample outputs.
REQ-010 SHALL have ports left and right, output, signed 16 bits, combinational: DAC-quantized xleft/xright.

Function
REQ-011 SHALL set op_val = {sign x2, noise, 0} when ne and op31_acc are both 1; otherwise op_val = op_out.
REQ-012 SHALL set sum_en from con_I: 0-3 -> m2_enters; 4 -> m1_enters|m2_enters; 5,6 -> NOT c1_enters; 7 -> 1.
REQ-013 SHALL hold per-channel partial sums in an 8-stage, 16-bit delay line; total = its output, opsum = its input.
REQ-014 SHALL, when c2_enters=1, set opsum = sign-extended op_val if sum_en, else 0.
REQ-015 SHALL otherwise, when sum_en=1, set opsum = total + op_val in 17 bits, saturated to 0x7FFF / 0x8000 on overflow.
REQ-016 SHALL otherwise set opsum = total.
REQ-017 SHALL, on c2_enters with sum_all=0, load pre_left = total if len else 0, load pre_right likewise with ren, and set sum_all=1.
REQ-018 SHALL, on c2_enters with sum_all=1, add those same gated terms to pre_left/pre_right (16-bit wrap, no saturation).
REQ-019 SHALL, on c1_enters, copy pre_left to xleft and pre_right to xright and clear sum_all.
REQ-020 SHALL, when c1_enters and c2_enters coincide, apply both updates; sum_all ends 0.
REQ-021 SHALL derive left/right via lin-to-exp then exp-to-lin (both combinational):
- lin-to-exp: exp = 7..1 from the count of leading sign-equal bits in lin[15:9].
- Top two bits differ -> exp 7, man = lin[15:6]; one fewer leading bit per exp step; exp 1 -> man = lin[9:0].
REQ-022 SHALL reconstruct lin = sign-extended man << (exp-1); exp 0 SHALL yield 0.

Reset
REQ-023 SHALL clear to 0 on rst: sum_all, pre_left, pre_right, xleft, xright and all delay-line stages; left/right therefore read 0.
REQ-024 SHALL give rst priority over every strobe; a reset mid-sample discards partial sums.

Structure
REQ-025 SHALL implement the delay line as sub-module jt51_sh, parameterised by width (16) and stages (8), with clk/rst ports.
REQ-026 SHALL implement the quantizer as sub-modules jt51_lin2exp and jt51_exp2lin, instantiated once per side.
REQ-027 SHALL place in a shared package: widths (14, 16, 10, 3) and the saturation constants 0x7FFF and 0x8000.

Verification
REQ-028 SHALL check xleft=0x0123 -> man=291, exp=1, left=0x0123.
REQ-029 SHALL check xleft=0x7FFF -> exp=7, man=0x1FF, left=0x7FC0; and xleft=0x8000 -> left=0x8000.
REQ-030 SHALL check ne=1, op31_acc=1, noise=-1024 -> op_val=-2048; with op31_acc=0 -> op_val=op_out.
REQ-031 SHALL check con_I=7, rl_I=2'b01, op_out=100 for all 32 slots -> after one c1_enters, xleft=400 per channel summed, xright=0.
REQ-032 SHALL check total=0x7F00 plus op_val=0x1000 with sum_en=1 and no c2_enters -> opsum=0x7FFF.
REQ-033 SHALL check rst asserted mid-sample -> xleft=xright=0 and the next sample is free of stale partial sums.
